// File: rtl/nand_flash_sequencer.sv
// NAND flash command sequencer: drives command/address/data/confirm cycles,
// waits for the memory's ready status and streams whole pages to/from the page buffer.
module nand_flash_sequencer #(
    parameter int         DW         = 8,
    parameter int         COL_CYCLES = 2,
    parameter int         ROW_CYCLES = 3,
    parameter int         PAGE_BYTES = 2048,
    parameter int         BUSY_DLY   = 2,
    parameter int         TIMEOUT    = 65535,
    parameter logic [7:0] MC_READ1   = 8'h00,
    parameter logic [7:0] MC_READ2   = 8'h30,
    parameter logic [7:0] MC_PROG1   = 8'h80,
    parameter logic [7:0] MC_PROG2   = 8'h10,
    parameter logic [7:0] MC_ERASE1  = 8'h60,
    parameter logic [7:0] MC_ERASE2  = 8'hD0,
    parameter logic [7:0] MC_RESET   = 8'hFF
) (
    input  logic                                  clk,
    input  logic                                  Reset,
    input  logic                                  nfc_start,
    input  logic [2:0]                            nfc_cmd,
    input  logic [(COL_CYCLES+ROW_CYCLES)*DW-1:0] nfc_addr,
    output logic                                  nfc_done,
    output logic                                  command_error,
    output logic                                  timeout_error,
    output logic                                  busy,
    output logic                                  cEn,
    output logic                                  CLE,
    output logic                                  ALE,
    output logic                                  wEn,
    output logic                                  rEn,
    output logic [DW-1:0]                         dio_out,
    output logic                                  dio_oe,
    input  logic [DW-1:0]                         dio_in,
    input  logic                                  status,
    output logic                                  buf_rd_en,
    input  logic [DW-1:0]                         buf_rd_data,
    output logic                                  buf_wr_en,
    output logic [DW-1:0]                         buf_wr_data
);

    localparam int NCYC = COL_CYCLES + ROW_CYCLES;
    localparam int AW   = NCYC * DW;
    localparam int AIW  = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam int BW   = $clog2(PAGE_BYTES + 1);
    localparam int WW   = $clog2(TIMEOUT + 1);

    localparam logic [2:0] CMD_ERASE = 3'd1;
    localparam logic [2:0] CMD_PROG  = 3'd2;
    localparam logic [2:0] CMD_READ  = 3'd3;
    localparam logic [2:0] CMD_RESET = 3'd4;

    typedef enum logic [2:0] {
        IDLE, CMD1, ADDR, DATA_OUT, CMD2, WAIT, DATA_IN, DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [2:0]      cmd_q;
    logic [AW-1:0]   addr_q;
    logic [AIW-1:0]  addr_idx;
    logic [AIW-1:0]  addr_idx_nxt;
    logic [AIW-1:0]  first_idx;
    logic [BW-1:0]   beat;
    logic [WW-1:0]   wcnt;
    logic [DW-1:0]   dio_out_q;
    logic            cmd_valid;
    logic            addr_last;
    logic            beat_last;
    logic            wait_ready;
    logic            wait_expired;

    function automatic logic [DW-1:0] first_code(input logic [2:0] c);
        case (c)
            CMD_ERASE: return DW'(MC_ERASE1);
            CMD_PROG:  return DW'(MC_PROG1);
            CMD_READ:  return DW'(MC_READ1);
            CMD_RESET: return DW'(MC_RESET);
            default:   return '0;
        endcase
    endfunction

    function automatic logic [DW-1:0] second_code(input logic [2:0] c);
        case (c)
            CMD_ERASE: return DW'(MC_ERASE2);
            CMD_PROG:  return DW'(MC_PROG2);
            CMD_READ:  return DW'(MC_READ2);
            default:   return '0;
        endcase
    endfunction

    function automatic logic [DW-1:0] addr_byte(input logic [AW-1:0] a, input logic [AIW-1:0] i);
        return a[int'(i)*DW +: DW];
    endfunction

    assign cmd_valid    = (nfc_cmd >= CMD_ERASE) && (nfc_cmd <= CMD_RESET);
    // Erase sends only the row bytes, which sit above the column bytes.
    assign first_idx    = (cmd_q == CMD_ERASE) ? AIW'(COL_CYCLES) : '0;
    assign addr_idx_nxt = (state == CMD1) ? first_idx : addr_idx + AIW'(1);
    assign addr_last    = (int'(addr_idx) == NCYC - 1);
    assign beat_last    = (int'(beat) == PAGE_BYTES - 1);
    assign wait_ready   = (int'(wcnt) >= BUSY_DLY) && status;
    assign wait_expired = (int'(wcnt) + 1 >= TIMEOUT);

    // The page buffer is first-word-fall-through, so its head goes straight to the bus.
    assign dio_out     = (state == DATA_OUT) ? buf_rd_data : dio_out_q;
    assign buf_wr_data = dio_in;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (nfc_start) state_nxt = cmd_valid ? CMD1 : DONE;
            CMD1:     state_nxt = (cmd_q == CMD_RESET) ? WAIT : ADDR;
            ADDR:     if (addr_last) state_nxt = (cmd_q == CMD_PROG) ? DATA_OUT : CMD2;
            DATA_OUT: if (beat_last) state_nxt = CMD2;
            CMD2:     state_nxt = WAIT;
            WAIT: begin
                if (wait_ready)        state_nxt = (cmd_q == CMD_READ) ? DATA_IN : DONE;
                else if (wait_expired) state_nxt = DONE;
            end
            DATA_IN:  if (beat_last) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state         <= IDLE;
            nfc_done      <= 1'b0;
            command_error <= 1'b0;
            timeout_error <= 1'b0;
            busy          <= 1'b0;
            cEn           <= 1'b0;
            CLE           <= 1'b0;
            ALE           <= 1'b0;
            wEn           <= 1'b0;
            rEn           <= 1'b0;
            dio_oe        <= 1'b0;
            buf_rd_en     <= 1'b0;
            buf_wr_en     <= 1'b0;
            dio_out_q     <= '0;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != IDLE);
            cEn       <= (state_nxt != IDLE) && (state_nxt != DONE);
            CLE       <= (state_nxt == CMD1) || (state_nxt == CMD2);
            ALE       <= (state_nxt == ADDR);
            wEn       <= (state_nxt == DATA_OUT);
            buf_rd_en <= (state_nxt == DATA_OUT);
            rEn       <= (state_nxt == DATA_IN);
            buf_wr_en <= (state_nxt == DATA_IN);
            dio_oe    <= (state_nxt == CMD1) || (state_nxt == ADDR) ||
                         (state_nxt == DATA_OUT) || (state_nxt == CMD2);
            nfc_done  <= (state_nxt == DONE);

            if (state == IDLE && nfc_start && !cmd_valid)
                command_error <= 1'b1;
            else if (state_nxt == IDLE)
                command_error <= 1'b0;

            if (state == WAIT && !wait_ready && wait_expired)
                timeout_error <= 1'b1;
            else if (state_nxt == IDLE)
                timeout_error <= 1'b0;

            case (state_nxt)
                CMD1:    dio_out_q <= first_code(nfc_cmd);
                CMD2:    dio_out_q <= second_code(cmd_q);
                ADDR:    dio_out_q <= addr_byte(addr_q, addr_idx_nxt);
                default: dio_out_q <= '0;
            endcase
        end
    end

    // Command latch and sequencing counters; only meaningful in the states that use them.
    always_ff @(posedge clk) begin
        if (state == IDLE && nfc_start) begin
            cmd_q  <= nfc_cmd;
            addr_q <= nfc_addr;
        end
        if (state == CMD1 || state == ADDR)
            addr_idx <= addr_idx_nxt;
        beat <= (state == DATA_OUT || state == DATA_IN) ? beat + BW'(1) : '0;
        wcnt <= (state == WAIT) ? wcnt + WW'(1) : '0;
    end

endmodule

// File: tb/tb_nand_flash_sequencer.sv
// Scoreboard bench for nand_flash_sequencer: expected bus events are queued at issue
// time and a negedge monitor compares every strobe cycle and completion pulse.
module tb_nand_flash_sequencer;

    localparam int DW   = 8;
    localparam int C    = 5;
    localparam int ROWC = 3;
    localparam int PAGE = 2048;
    localparam int TMO  = 16;
    localparam int WMIN = 3;

    localparam int K_CLE  = 0;
    localparam int K_ALE  = 1;
    localparam int K_WR   = 2;
    localparam int K_BW   = 3;
    localparam int K_DONE = 4;

    logic          clk = 1'b0;
    logic          Reset;
    logic          nfc_start;
    logic [2:0]    nfc_cmd;
    logic [39:0]   nfc_addr;
    logic          nfc_done, command_error, timeout_error, busy;
    logic          cEn, CLE, ALE, wEn, rEn;
    logic [DW-1:0] dio_out;
    logic          dio_oe;
    logic [DW-1:0] dio_in;
    logic          status;
    logic          buf_rd_en;
    logic [DW-1:0] buf_rd_data;
    logic          buf_wr_en;
    logic [DW-1:0] buf_wr_data;

    always #5 clk = ~clk;

    nand_flash_sequencer #(.TIMEOUT(TMO)) dut (
        .clk(clk), .Reset(Reset), .nfc_start(nfc_start), .nfc_cmd(nfc_cmd),
        .nfc_addr(nfc_addr), .nfc_done(nfc_done), .command_error(command_error),
        .timeout_error(timeout_error), .busy(busy), .cEn(cEn), .CLE(CLE), .ALE(ALE),
        .wEn(wEn), .rEn(rEn), .dio_out(dio_out), .dio_oe(dio_oe), .dio_in(dio_in),
        .status(status), .buf_rd_en(buf_rd_en), .buf_rd_data(buf_rd_data),
        .buf_wr_en(buf_wr_en), .buf_wr_data(buf_wr_data)
    );

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         mem_busy_len = 0;
    logic [7:0] bufmem [PAGE];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic push(input int k, input logic [7:0] d, input int c);
        exp_t e;
        e.kind = k;
        e.data = d;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic push_addr(input logic [39:0] a, input int first);
        for (int i = first; i < C; i++) push(K_ALE, 8'(a >> (8 * i)), 0);
    endtask

    task automatic observe(input int kind, input logic [7:0] data);
        exp_t e;
        if (sb.size() == 0) begin
            check(1'b0, "unexpected_event", longint'(kind) * 256 + data, 0);
        end else begin
            e = sb.pop_front();
            check(e.kind == kind && e.data == data, "bus_event",
                  longint'(kind) * 256 + data, longint'(e.kind) * 256 + e.data);
            if (kind == K_DONE && e.kind == K_DONE)
                check(cyc == e.cyc, "done_cycle", cyc, e.cyc);
        end
    endtask

    // Monitor: every strobe cycle is one scoreboard event.
    initial begin
        forever begin
            @(negedge clk);
            if (CLE)       observe(K_CLE, dio_out);
            if (ALE)       observe(K_ALE, dio_out);
            if (wEn)       observe(K_WR, dio_out);
            if (buf_wr_en) observe(K_BW, buf_wr_data);
            if (nfc_done)  observe(K_DONE, {6'b0, command_error, timeout_error});
            if (rEn)       check(!dio_oe, "oe_during_ren", dio_oe, 0);
        end
    end

    // Memory and page-buffer model; a negative busy length keeps status low forever.
    initial begin
        int rd_idx;
        int bptr;
        int bcnt;
        for (int i = 0; i < PAGE; i++) bufmem[i] = (i % 2 == 0) ? 8'hA5 : 8'h5A;
        status = 1'b1;
        dio_in = '0;
        rd_idx = 0;
        bptr = 0;
        bcnt = 0;
        buf_rd_data = bufmem[0];
        forever begin
            @(posedge clk);
            #1;
            if (CLE) begin
                rd_idx = 0;
                bptr = 0;
                buf_rd_data = bufmem[0];
                if ((dio_out == 8'h30 || dio_out == 8'h10 || dio_out == 8'hD0 ||
                     dio_out == 8'hFF) && mem_busy_len != 0) begin
                    status = 1'b0;
                    bcnt = mem_busy_len;
                end
            end else if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) status = 1'b1;
            end
            if (rEn) begin
                dio_in = 8'(rd_idx);
                rd_idx++;
            end
            if (buf_rd_en) begin
                buf_rd_data = bufmem[bptr];
                bptr++;
            end
        end
    end

    task automatic check_idle(input string name);
        logic [19:0] v;
        v = {cEn, CLE, ALE, wEn, rEn, nfc_done, command_error, timeout_error,
             busy, dio_oe, buf_rd_en, buf_wr_en, dio_out};
        check(v == '0, name, v, 0);
    endtask

    task automatic start_cmd(input logic [2:0] cmd, input logic [39:0] addr, output int sc);
        @(negedge clk);
        nfc_cmd   = cmd;
        nfc_addr  = addr;
        nfc_start = 1'b1;
        sc = cyc + 1;
    endtask

    task automatic wait_done(input int limit, input string name);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(n < limit, name, n, limit);
    endtask

    function automatic int wait_cycles(input int blen);
        return (blen > WMIN) ? blen : WMIN;
    endfunction

    task automatic do_read(input logic [39:0] addr, input int blen);
        int sc;
        mem_busy_len = blen;
        start_cmd(3'd3, addr, sc);
        push(K_CLE, 8'h00, 0);
        push_addr(addr, 0);
        push(K_CLE, 8'h30, 0);
        for (int i = 0; i < PAGE; i++) push(K_BW, 8'(i), 0);
        push(K_DONE, 8'h00, sc + (1 + C + 1 + wait_cycles(blen) + PAGE + 1) - 1);
        @(negedge clk);
        nfc_start = 1'b0;
        wait_done(5000, "read_complete");
    endtask

    task automatic do_prog(input logic [39:0] addr, input int blen);
        int sc;
        mem_busy_len = blen;
        start_cmd(3'd2, addr, sc);
        push(K_CLE, 8'h80, 0);
        push_addr(addr, 0);
        for (int i = 0; i < PAGE; i++) push(K_WR, (i % 2 == 0) ? 8'hA5 : 8'h5A, 0);
        push(K_CLE, 8'h10, 0);
        push(K_DONE, 8'h00, sc + (1 + C + PAGE + 1 + wait_cycles(blen) + 1) - 1);
        @(negedge clk);
        nfc_start = 1'b0;
        wait_done(5000, "prog_complete");
    endtask

    task automatic do_erase(input logic [39:0] addr, input int blen, input bit expect_to);
        int sc;
        int w;
        mem_busy_len = blen;
        w = expect_to ? TMO : wait_cycles(blen);
        start_cmd(3'd1, addr, sc);
        push(K_CLE, 8'h60, 0);
        push_addr(addr, 2);
        push(K_CLE, 8'hD0, 0);
        push(K_DONE, {7'b0, expect_to}, sc + (1 + ROWC + 1 + w + 1) - 1);
        @(negedge clk);
        nfc_start = 1'b0;
        wait_done(500, "erase_complete");
    endtask

    task automatic do_mem_reset(input int blen);
        int sc;
        mem_busy_len = blen;
        start_cmd(3'd4, 40'h0, sc);
        push(K_CLE, 8'hFF, 0);
        push(K_DONE, 8'h00, sc + (1 + wait_cycles(blen) + 1) - 1);
        @(negedge clk);
        nfc_start = 1'b0;
        wait_done(500, "memreset_complete");
    endtask

    initial begin
        int sc;
        Reset     = 1'b1;
        nfc_start = 1'b0;
        nfc_cmd   = '0;
        nfc_addr  = '0;
        repeat (3) @(negedge clk);
        check_idle("reset_state");
        Reset = 1'b0;

        do_read(40'h03_0201_0005, 10);
        do_prog(40'h12_3456_0000, 7);
        do_erase({24'h00_0102, 16'hBEEF}, 5, 1'b0);

        // Invalid command: done with command_error straight after the start edge.
        start_cmd(3'd7, 40'h0, sc);
        push(K_DONE, 8'h02, sc);
        @(negedge clk);
        nfc_start = 1'b0;
        check(busy == 1'b1, "invalid_busy_in_done", busy, 1);
        @(negedge clk);
        check(busy == 1'b0, "invalid_busy_drop", busy, 0);
        check(command_error == 1'b0, "invalid_flag_clear", command_error, 0);

        do_erase({24'h00_0102, 16'h0000}, -1, 1'b1);
        do_mem_reset(4);

        // Reset during the program data phase at beat 100.
        mem_busy_len = 7;
        start_cmd(3'd2, 40'h00_0000_0100, sc);
        push(K_CLE, 8'h80, 0);
        push_addr(40'h00_0000_0100, 0);
        for (int i = 0; i <= 100; i++) push(K_WR, (i % 2 == 0) ? 8'hA5 : 8'h5A, 0);
        @(negedge clk);
        nfc_start = 1'b0;
        repeat (106) @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        check_idle("reset_mid_data");
        check(sb.size() == 0, "beats_before_reset", sb.size(), 0);
        Reset = 1'b0;
        repeat (8) @(negedge clk);
        check_idle("idle_after_reset");

        do_read(40'h01_0000_0002, 3);

        repeat (3) @(negedge clk);
        check(sb.size() == 0, "scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
